maxima_uart_tx: RTL

- Consumer end of the shazam_core peak interface.
- On each rising edge of maximas_found_active it snapshots the maximas array and serializes it as one checksummed frame over a UART 8N1 line to the host PC.
- Sits between shazam_core and the board TX pin. It replaces file dumping of peaks in simulation with a hardware path to the host.

---
 rtl/maxima_uart_tx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/maxima_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// maxima_uart_tx : snapshots a shazam_core maxima set on each rising edge of
//                  maximas_found_active and sends it as one checksummed 8N1 frame
// Revision       : 1.0
// ============================================================================

module maxima_uart_tx #(
  parameter int         MAXIMAS_COUNT = 10,
  parameter int         CLK_FREQ      = 50000000,
  parameter int         BAUD          = 115200,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] maximas [MAXIMAS_COUNT],
  input  logic        maximas_found_active,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frames_dropped
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int FRAME_BYTES  = 4 * MAXIMAS_COUNT + 3;
  localparam int IDX_W        = $clog2(FRAME_BYTES + 1);
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_BYTES - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t            state;
  logic              prev;
  logic [24:0]       shadow [MAXIMAS_COUNT];
  logic [IDX_W-1:0]  byte_idx;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic [7:0]        checksum;

  logic              rise;
  logic              baud_end;
  logic [IDX_W-1:0]  rel;
  logic [IDX_W-1:0]  entry_sel;
  logic [24:0]       cur_entry;
  logic [7:0]        cur_byte;

  assign rise      = maximas_found_active & ~prev;
  assign baud_end  = (baud_cnt == BAUD_LAST);
  // Payload bytes start at index 2; each entry occupies four consecutive bytes.
  assign rel       = byte_idx - IDX_W'(2);
  assign entry_sel = rel >> 2;

  always_comb begin
    cur_entry = '0;
    for (int i = 0; i < MAXIMAS_COUNT; i++) begin
      if (entry_sel == IDX_W'(i)) begin
        cur_entry = shadow[i];
      end
    end
  end

  always_comb begin
    cur_byte = '0;
    if (byte_idx == '0) begin
      cur_byte = SYNC_BYTE;
    end else if (byte_idx == IDX_W'(1)) begin
      cur_byte = 8'(MAXIMAS_COUNT);
    end else if (byte_idx == LAST_IDX) begin
      cur_byte = checksum;
    end else begin
      case (rel[1:0])
        2'd0:    cur_byte = {7'b0, cur_entry[24]};
        2'd1:    cur_byte = cur_entry[23:16];
        2'd2:    cur_byte = cur_entry[15:8];
        default: cur_byte = cur_entry[7:0];
      endcase
    end
  end

  // tx is registered from the current state, so the line lags the FSM by one
  // cycle; LOAD therefore shows up as the single idle-high gap between bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      prev           <= 1'b0;
      tx             <= 1'b1;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      frames_dropped <= '0;
      byte_idx       <= '0;
      baud_cnt       <= '0;
      bit_cnt        <= '0;
      shift          <= '0;
      checksum       <= '0;
      for (int i = 0; i < MAXIMAS_COUNT; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      prev       <= maximas_found_active;
      frame_done <= 1'b0;

      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift[0];
        default: tx <= 1'b1;
      endcase

      if (rise && (state != IDLE) && (frames_dropped != 8'hFF)) begin
        frames_dropped <= frames_dropped + 8'd1;
      end

      case (state)
        IDLE: begin
          if (rise) begin
            for (int i = 0; i < MAXIMAS_COUNT; i++) begin
              shadow[i] <= maximas[i];
            end
            busy     <= 1'b1;
            byte_idx <= '0;
            checksum <= '0;
            state    <= LOAD;
          end
        end

        LOAD: begin
          shift    <= cur_byte;
          baud_cnt <= '0;
          // Sync byte and the checksum byte itself are excluded from the XOR.
          if ((byte_idx != '0) && (byte_idx != LAST_IDX)) begin
            checksum <= checksum ^ cur_byte;
          end
          state <= START;
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (byte_idx == LAST_IDX) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
              state    <= LOAD;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
